// File: rtl/gate_resp_checker_if.sv
// Stimulus/response bundle between a 2-input gate DUT harness and its checker.
// The master side drives stimulus and the DUT output; the slave side is the checker.
interface gate_resp_checker_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             stim_vld;
  logic             stim_a;
  logic             stim_b;
  logic             dut_y;
  logic             stim_rdy;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic [1:0]       first_fail_vec;
  logic             first_fail_vld;
  logic [3:0]       cov_mask;

  modport master (
    output start, stim_vld, stim_a, stim_b, dut_y,
    input  stim_rdy, busy, done, pass, err_cnt, chk_cnt,
           first_fail_vec, first_fail_vld, cov_mask
  );

  modport slave (
    input  start, stim_vld, stim_a, stim_b, dut_y,
    output stim_rdy, busy, done, pass, err_cnt, chk_cnt,
           first_fail_vec, first_fail_vld, cov_mask
  );
endinterface

// File: rtl/gate_resp_checker.sv
// Response checker for a 2-input gate DUT. Accepts one {a,b} vector at a time,
// waits SETTLE edges, samples dut_y and compares against the golden gate.
// Tracks error/check counts, first failing vector and truth-table coverage.
module gate_resp_checker #(
  parameter int OP      = 0,   // 0=AND 1=OR 2=XOR 3=NAND
  parameter int SETTLE  = 2,   // edges from accept to sample, >= 1
  parameter int MAX_CHK = 16,  // check count that forces completion
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  gate_resp_checker_if.slave bus
);

  // Settle counter holds SETTLE-1 down to 0; sample happens when it reads 0.
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0]  SC_LOAD   = SC_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_CHK_C = CNT_W'(MAX_CHK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic golden(input logic a, input logic b);
    case (OP)
      0:       golden = a & b;
      1:       golden = a | b;
      2:       golden = a ^ b;
      3:       golden = ~(a & b);
      default: golden = 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [3:0]       cov_q, cov_d;
  logic [1:0]       ffv_q, ffv_d;
  logic             ffvld_q, ffvld_d;
  logic             pass_q, pass_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             exp_s;
  logic             clear_s;

  // State register and all registered outputs; everything zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 2'b00;
      sc_q    <= '0;
      err_q   <= '0;
      chk_q   <= '0;
      cov_q   <= 4'h0;
      ffv_q   <= 2'b00;
      ffvld_q <= 1'b0;
      pass_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sc_q    <= sc_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ffvld_q <= ffvld_d;
      pass_q  <= pass_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, accept/sample bookkeeping and next values of the status outputs.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    sc_d    = sc_q;
    err_d   = err_q;
    chk_d   = chk_q;
    cov_d   = cov_q;
    ffv_d   = ffv_q;
    ffvld_d = ffvld_q;
    pass_d  = pass_q;
    exp_s   = golden(vec_q[1], vec_q[0]);
    clear_s = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          clear_s = 1'b1;
          state_d = S_ARM;
        end else begin
          state_d = state_q;
        end
      end
      S_ARM: begin
        // stim_rdy is high for the whole of ARM, so valid alone accepts.
        if (bus.stim_vld) begin
          vec_d   = {bus.stim_a, bus.stim_b};
          sc_d    = SC_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_ARM;
        end
      end
      S_WAIT: begin
        if (sc_q == '0) begin
          chk_d = sat_inc(chk_q);
          cov_d = cov_q | (4'b0001 << vec_q);
          if (bus.dut_y != exp_s) begin
            err_d = sat_inc(err_q);
            if (!ffvld_q) begin
              ffv_d   = vec_q;
              ffvld_d = 1'b1;
            end else begin
              ffv_d   = ffv_q;
            end
          end else begin
            err_d = err_q;
          end
          if ((cov_d == 4'hF) || (chk_d == MAX_CHK_C)) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0) && (cov_d == 4'hF);
          end else begin
            state_d = S_ARM;
          end
        end else begin
          sc_d = sc_q - SC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new run wipes every result field.
    if (clear_s) begin
      err_d   = '0;
      chk_d   = '0;
      cov_d   = 4'h0;
      ffv_d   = 2'b00;
      ffvld_d = 1'b0;
      pass_d  = 1'b0;
    end else begin
      pass_d  = pass_d;
    end

    rdy_d  = (state_d == S_ARM);
    busy_d = (state_d == S_ARM) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  assign bus.stim_rdy       = rdy_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_q;
  assign bus.chk_cnt        = chk_q;
  assign bus.first_fail_vec = ffv_q;
  assign bus.first_fail_vld = ffvld_q;
  assign bus.cov_mask       = cov_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: the stimulus process predicts each
// check result from the truth table and queues it; a monitor pops and compares
// whenever chk_cnt advances.
module tb_gate_resp_checker;
  localparam int OP      = 0;
  localparam int SETTLE  = 2;
  localparam int MAX_CHK = 16;
  localparam int CNT_W   = 8;

  typedef struct {
    int chk;
    int err;
    int cov;
    int ffv;
    int ffvld;
    int done;
    int pass;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // reference model state
  int m_chk, m_err, m_cov, m_ffv, m_ffvld, m_done;
  logic [3:0] tt;

  gate_resp_checker_if #(.CNT_W(CNT_W)) bus ();

  gate_resp_checker #(
    .OP(OP), .SETTLE(SETTLE), .MAX_CHK(MAX_CHK), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int golden(input int a, input int b);
    logic [1:0] idx;
    idx = 2'(a * 2 + b);
    return int'(tt[idx]);
  endfunction

  function automatic int outputs_or();
    return int'(bus.stim_rdy | bus.busy | bus.done | bus.pass |
                (|bus.err_cnt) | (|bus.chk_cnt) | (|bus.first_fail_vec) |
                bus.first_fail_vld | (|bus.cov_mask));
  endfunction

  // Monitor: each advance of chk_cnt is one DUT result; compare with the queue head.
  initial begin
    int last;
    exp_t e;
    last = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && int'(bus.chk_cnt) != last && bus.chk_cnt != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_check", int'(bus.chk_cnt), 0);
        end else begin
          e = sb_q.pop_front();
          check("mon_chk_cnt", int'(bus.chk_cnt), e.chk);
          check("mon_err_cnt", int'(bus.err_cnt), e.err);
          check("mon_cov_mask", int'(bus.cov_mask), e.cov);
          check("mon_ff_vld", int'(bus.first_fail_vld), e.ffvld);
          if (e.ffvld != 0) check("mon_ff_vec", int'(bus.first_fail_vec), e.ffv);
          check("mon_done", int'(bus.done), e.done);
          if (e.done != 0) check("mon_pass", int'(bus.pass), e.pass);
        end
      end
      last = int'(bus.chk_cnt);
    end
  end

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m_chk = 0; m_err = 0; m_cov = 0; m_ffv = 0; m_ffvld = 0; m_done = 0;
    check("start_rdy", int'(bus.stim_rdy), 1);
    check("start_clear", int'(bus.chk_cnt) + int'(bus.err_cnt) + int'(bus.cov_mask)
          + int'(bus.done) + int'(bus.first_fail_vld), 0);
  endtask

  // Waits for stim_rdy at a falling edge; returns 0 on timeout.
  task automatic wait_rdy(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.stim_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.stim_rdy;
    if (!ok) check("rdy_timeout", 0, 1);
  endtask

  task automatic send(input int a, input int b, input bit bad, input bit glitch, input bit hold);
    bit   ok;
    int   y;
    exp_t e;
    wait_rdy(ok);
    if (ok) begin
      y = golden(a, b);
      if (bad) y = 1 - y;
      bus.stim_a   = 1'(a);
      bus.stim_b   = 1'(b);
      bus.stim_vld = 1'b1;
      bus.dut_y    = 1'(y);
      m_chk++;
      m_cov = m_cov | (1 << (a * 2 + b));
      if (bad) begin
        m_err++;
        if (m_ffvld == 0) begin
          m_ffv = a * 2 + b;
          m_ffvld = 1;
        end
      end
      m_done = (m_cov == 15 || m_chk == MAX_CHK) ? 1 : 0;
      e.chk = m_chk; e.err = m_err; e.cov = m_cov; e.ffv = m_ffv; e.ffvld = m_ffvld;
      e.done = m_done; e.pass = (m_err == 0 && m_cov == 15) ? 1 : 0;
      sb_q.push_back(e);
      @(negedge clk);
      if (!hold) bus.stim_vld = 1'b0;
      if (glitch) bus.dut_y = 1'(1 - y);
      repeat (SETTLE - 1) @(negedge clk);
      bus.stim_vld = 1'b0;
      bus.dut_y    = 1'(y);
    end
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, sb_q.size(), 0);
    @(negedge clk);
    check({tag, "_done"}, int'(bus.done), m_done);
    check({tag, "_pass"}, int'(bus.pass), (m_done != 0 && m_err == 0 && m_cov == 15) ? 1 : 0);
    check({tag, "_err"}, int'(bus.err_cnt), m_err);
    check({tag, "_chk"}, int'(bus.chk_cnt), m_chk);
    check({tag, "_cov"}, int'(bus.cov_mask), m_cov);
  endtask

  initial begin
    bit ok;
    int n;
    tt = (OP == 0) ? 4'b1000 : (OP == 1) ? 4'b1110 : (OP == 2) ? 4'b0110 : 4'b0111;
    bus.start = 1'b0; bus.stim_vld = 1'b0; bus.stim_a = 1'b0; bus.stim_b = 1'b0; bus.dut_y = 1'b0;
    m_chk = 0; m_err = 0; m_cov = 0; m_ffv = 0; m_ffvld = 0; m_done = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outputs_or(), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: mid-cycle async reset while armed
    do_start();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", outputs_or(), 0);
    check("async_rst_rdy", int'(bus.stim_rdy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_rdy", int'(bus.stim_rdy) + int'(bus.busy), 0);

    // 2: full correct run
    do_start();
    send(1, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(0, 0, 0, 0, 0); send(1, 0, 0, 0, 0);
    drain_and_check("t2");

    // start in DONE restarts; 3: wrong y on vector 01
    do_start();
    send(1, 1, 0, 0, 0); send(0, 1, 1, 0, 0); send(0, 0, 0, 0, 0); send(1, 0, 0, 0, 0);
    drain_and_check("t3");
    check("t3_ffvec", int'(bus.first_fail_vec), 1);
    check("t3_ffvld", int'(bus.first_fail_vld), 1);

    // 4: MAX_CHK limit with a single vector
    do_start();
    for (int i = 0; i < 16; i++) send(1, 1, 0, 0, 0);
    drain_and_check("t4");
    check("t4_rdy_after_done", int'(bus.stim_rdy), 0);

    // 5: valid held through WAIT plus a y glitch before the sample edge
    do_start();
    send(0, 1, 0, 1, 1);
    repeat (SETTLE + 3) @(negedge clk);
    check("t5_single_accept", int'(bus.chk_cnt), 1);
    check("t5_no_err", int'(bus.err_cnt), 0);
    send(1, 1, 0, 0, 0); send(0, 0, 0, 0, 0); send(1, 0, 0, 0, 0);
    drain_and_check("t5");

    // 6: reset during WAIT after two checks, then a clean run
    do_start();
    send(1, 1, 0, 0, 0); send(0, 0, 0, 0, 0);
    wait_rdy(ok);
    bus.stim_a = 1'b0; bus.stim_b = 1'b1; bus.stim_vld = 1'b1; bus.dut_y = 1'b0;
    @(posedge clk);
    #1;
    bus.stim_vld = 1'b0;
    check("t6_in_wait", int'(bus.busy) * 2 + int'(bus.stim_rdy), 2);
    rst = 1'b1;
    #1;
    check("t6_rst_outputs", outputs_or(), 0);
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b0;
    do_start();
    send(1, 0, 0, 0, 0); send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0); send(0, 0, 0, 0, 0);
    drain_and_check("t6");

    // random runs: random vectors, errors, glitches and held valid
    for (int r = 0; r < 6; r++) begin
      do_start();
      n = 0;
      while (m_done == 0 && n < 40) begin
        send(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
             ($urandom_range(5, 0) == 0), ($urandom_range(2, 0) == 0),
             ($urandom_range(2, 0) == 0));
        n++;
      end
      drain_and_check("rand");
      if (m_ffvld != 0) check("rand_ffvec", int'(bus.first_fail_vec), m_ffv);
      check("rand_ffvld", int'(bus.first_fail_vld), m_ffvld);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
